// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the RV32I fetch stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC mux, next fetch state, and misalignment/range fault detection.
module pc_next
  import pipe_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64
) (
  input  fetch_state_t state_i,
  input  logic [31:0]  pc_i,
  input  logic         stall_f_i,
  input  logic         redirect_i,
  input  logic [31:0]  target_i,
  output logic [31:0]  pc_o,
  output logic [31:0]  pc_plus4_o,
  output fetch_state_t state_o,
  output logic         fetch_ok_o
);

  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

  logic [31:0] tgt_al;
  logic        pc_in_range;
  logic        tgt_in_range;

  assign tgt_al       = {target_i[31:2], 2'b00};
  assign pc_plus4_o   = pc_i + 32'd4;
  assign pc_in_range  = (pc_i < LIMIT);
  assign tgt_in_range = (tgt_al < LIMIT);

  always_comb begin
    pc_o       = pc_i;
    state_o    = state_i;
    fetch_ok_o = 1'b0;
    unique case (state_i)
      BOOT: state_o = RUN;
      RUN: begin
        if (redirect_i) begin
          // A redirect suppresses the range check on the current PC.
          if (target_i[1]) begin
            state_o = FAULT;
          end else begin
            pc_o       = tgt_al;
            fetch_ok_o = 1'b1;
          end
        end else if (!pc_in_range) begin
          state_o = FAULT;
        end else begin
          fetch_ok_o = 1'b1;
          if (!stall_f_i) pc_o = pc_plus4_o;
        end
      end
      FAULT: begin
        if (redirect_i && !target_i[1] && tgt_in_range) begin
          pc_o    = tgt_al;
          state_o = RUN;
        end
      end
      default: state_o = BOOT;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, fetch FSM and IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_e,
  input  logic [31:0] target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_fault
);

  import pipe_pkg::*;

  fetch_state_t state_q, state_n;
  logic [31:0]  pc_q, pc_n, pc_plus4;
  logic         fetch_ok;
  logic         fault_q;
  ifid_t        ifid_q, ifid_d;

  pc_next #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_pc_next (
    .state_i   (state_q),
    .pc_i      (pc_q),
    .stall_f_i (stall_f),
    .redirect_i(redirect_e),
    .target_i  (target_e),
    .pc_o      (pc_n),
    .pc_plus4_o(pc_plus4),
    .state_o   (state_n),
    .fetch_ok_o(fetch_ok)
  );

  // Outside RUN, on flush, or when a fault applies, IF/ID takes a bubble;
  // stall_d only holds IF/ID in RUN when no flush is requested.
  always_comb begin
    ifid_d = ifid_q;
    if (state_q != RUN || flush_d) begin
      ifid_d = ifid_bubble(NOP_INSTR);
    end else if (!stall_d) begin
      if (fetch_ok) begin
        ifid_d.instr    = imem_rd;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.valid    = 1'b1;
      end else begin
        ifid_d = ifid_bubble(NOP_INSTR);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= ifid_bubble(NOP_INSTR);
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ifid_q  <= ifid_d;
      fault_q <= (state_n == FAULT);
    end
  end

  assign imem_addr   = pc_q;
  assign instr_d     = ifid_q.instr;
  assign pc_d        = ifid_q.pc;
  assign pc_plus4_d  = ifid_q.pc_plus4;
  assign valid_d     = ifid_q.valid;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a 64-word imem model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_f, stall_d, flush_d, redirect_e;
  logic [31:0] target_e;
  logic [31:0] imem_addr, imem_rd;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fetch_fault;

  logic [31:0] mem [64];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(64),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .redirect_e (redirect_e),
    .target_e   (target_e),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    redirect_e = 1'b0;
    target_e   = '0;
  endtask

  initial begin
    int unsigned budget;
    for (int unsigned i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0000_0113;
    mem[2] = 32'h0010_0113;

    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    check("rst_addr",  imem_addr,   32'h0);
    check("rst_instr", instr_d,     NOP);
    check("rst_pc_d",  pc_d,        32'h0);
    check("rst_pc4_d", pc_plus4_d,  32'h0);
    check("rst_valid", {31'b0, valid_d},     32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);

    // 1: BOOT then sequential fetch
    reset_n = 1'b1;
    step();
    check("boot_addr",  imem_addr, 32'h0);
    check("boot_valid", {31'b0, valid_d}, 32'h0);
    step();
    check("f0_instr", instr_d, 32'h0050_0093);
    check("f0_pc",    pc_d,    32'h0);
    check("f0_pc4",   pc_plus4_d, 32'h4);
    check("f0_valid", {31'b0, valid_d}, 32'h1);
    check("f0_addr",  imem_addr, 32'h4);
    step();
    check("f1_instr", instr_d, 32'h0000_0113);
    check("f1_pc",    pc_d,    32'h4);
    check("f1_addr",  imem_addr, 32'h8);

    // 2: stall both at pc_f=8
    stall_f = 1'b1;
    stall_d = 1'b1;
    step();
    step();
    check("stall_addr",  imem_addr, 32'h8);
    check("stall_pc",    pc_d,      32'h4);
    check("stall_instr", instr_d,   32'h0000_0113);
    stall_f = 1'b0;
    stall_d = 1'b0;
    step();
    check("f2_instr", instr_d, 32'h0010_0113);
    check("f2_pc",    pc_d,    32'h8);
    step();
    check("f3_instr", instr_d, 32'h1000_0003);
    check("f3_pc",    pc_d,    32'hC);
    check("f3_addr",  imem_addr, 32'h10);

    // 3: backward branch with flush
    redirect_e = 1'b1;
    target_e   = 32'h4;
    flush_d    = 1'b1;
    step();
    idle_inputs();
    check("br_addr",  imem_addr, 32'h4);
    check("br_instr", instr_d,   NOP);
    check("br_valid", {31'b0, valid_d}, 32'h0);
    check("br_pc",    pc_d,      32'h0);
    step();
    check("br_tgt_pc",    pc_d,    32'h4);
    check("br_tgt_instr", instr_d, 32'h0000_0113);

    // 4: redirect beats stall_f
    redirect_e = 1'b1;
    stall_f    = 1'b1;
    target_e   = 32'h20;
    step();
    idle_inputs();
    check("rs_addr", imem_addr, 32'h20);
    check("rs_pc",   pc_d,      32'h8);
    check("rs_pc4",  pc_plus4_d, 32'hC);

    // 5: run off the end of imem
    budget = 100;
    while (imem_addr != 32'd256 && budget != 0) begin
      step();
      budget--;
    end
    check("reach_256_in_budget", {31'b0, (budget != 0)}, 32'h1);
    check("last_pc",    pc_d,    32'hFC);
    check("last_instr", instr_d, 32'h1000_003F);
    check("last_fault", {31'b0, fetch_fault}, 32'h0);
    step();
    check("rng_fault", {31'b0, fetch_fault}, 32'h1);
    check("rng_valid", {31'b0, valid_d},     32'h0);
    check("rng_addr",  imem_addr, 32'h100);
    redirect_e = 1'b1;
    target_e   = 32'h200;
    step();
    check("oor_redir_fault", {31'b0, fetch_fault}, 32'h1);
    check("oor_redir_addr",  imem_addr, 32'h100);
    target_e = 32'h0;
    step();
    idle_inputs();
    check("exit_fault", {31'b0, fetch_fault}, 32'h0);
    check("exit_addr",  imem_addr, 32'h0);
    check("exit_valid", {31'b0, valid_d}, 32'h0);
    step();
    check("resume_instr", instr_d, 32'h0050_0093);
    check("resume_valid", {31'b0, valid_d}, 32'h1);
    check("resume_addr",  imem_addr, 32'h4);

    // 6: misaligned redirect, then reset from FAULT
    redirect_e = 1'b1;
    target_e   = 32'h6;
    step();
    idle_inputs();
    check("mis_fault", {31'b0, fetch_fault}, 32'h1);
    check("mis_addr",  imem_addr, 32'h4);
    check("mis_valid", {31'b0, valid_d}, 32'h0);
    step();
    check("mis_hold_addr", imem_addr, 32'h4);
    reset_n = 1'b0;
    step();
    check("frst_addr",  imem_addr, 32'h0);
    check("frst_fault", {31'b0, fetch_fault}, 32'h0);
    reset_n    = 1'b1;
    redirect_e = 1'b1;
    target_e   = 32'h40;
    step();
    idle_inputs();
    check("boot_ign_redir_addr", imem_addr, 32'h0);
    check("boot2_valid", {31'b0, valid_d}, 32'h0);
    step();
    check("boot2_f0_valid", {31'b0, valid_d}, 32'h1);
    check("boot2_f0_instr", instr_d, 32'h0050_0093);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
